// File: rtl/vga_sprite_if.sv
// vga_sprite_if: pixel-stage bundle between the VGA timing generator / test
// driver (master) and the sprite pixel source (slave).
//   hcnt, vcnt        : current pixel column / line
//   hsync_in, vsync_in: raw syncs from the timing generator
//   en                : motion enable
//   r, g, b           : registered colour
//   hsync, vsync      : syncs re-timed to the colour
//   x, y              : sprite top-left position
//   bounces           : edge-reflection counter
`timescale 1ns/1ps
interface vga_sprite_if;
   logic [9:0] hcnt;
   logic [9:0] vcnt;
   logic       hsync_in;
   logic       vsync_in;
   logic       en;
   logic       r;
   logic       g;
   logic       b;
   logic       hsync;
   logic       vsync;
   logic [9:0] x;
   logic [9:0] y;
   logic [7:0] bounces;

   modport master (
      output hcnt, vcnt, hsync_in, vsync_in, en,
      input  r, g, b, hsync, vsync, x, y, bounces
   );

   modport slave (
      input  hcnt, vcnt, hsync_in, vsync_in, en,
      output r, g, b, hsync, vsync, x, y, bounces
   );
endinterface

// File: rtl/vga_sprite.sv
// vga_sprite: pixel source feeding the VGA colour pins. Draws a bouncing
// solid square over a background with a 1-pixel white frame around the
// active area, and delays the syncs by one clock so they leave together
// with the registered colour.
//   clk : pixel clock
//   rst : asynchronous reset, active low
//   bus : vga_sprite_if.slave (timing in, colour/sync/position out)
`timescale 1ns/1ps
module vga_sprite #(
   parameter int       H_ACTIVE = 640,
   parameter int       V_ACTIVE = 480,
   parameter int       SIZE     = 32,
   parameter int       STEP     = 2,
   parameter logic [2:0] FG     = 3'b110,
   parameter logic [2:0] BG     = 3'b001
) (
   input logic         clk,
   input logic         rst,
   vga_sprite_if.slave bus
);
   localparam logic [10:0] H_A    = 11'(H_ACTIVE);
   localparam logic [10:0] V_A    = 11'(V_ACTIVE);
   localparam logic [10:0] SIZE11 = 11'(SIZE);
   localparam logic [10:0] STEP11 = 11'(STEP);
   localparam logic [9:0]  STEP10 = 10'(STEP);
   localparam logic [9:0]  X_MAX  = 10'(H_ACTIVE - SIZE);
   localparam logic [9:0]  Y_MAX  = 10'(V_ACTIVE - SIZE);

   logic [2:0] rgb_q, rgb_d;
   logic       hsync_q, vsync_q;
   logic [9:0] x_q, x_d, y_q, y_d;
   logic       dir_x_q, dir_x_d;   // 1 = moving left
   logic       dir_y_q, dir_y_d;   // 1 = moving up
   logic [7:0] bounces_q, bounces_d;

   logic [10:0] h11, v11, x11, y11;
   logic        active_s, border_s, sprite_s, tick_s, refl_x_s, refl_y_s;

   // Pixel classification and colour selection.
   always_comb begin
      h11      = {1'b0, bus.hcnt};
      v11      = {1'b0, bus.vcnt};
      x11      = {1'b0, x_q};
      y11      = {1'b0, y_q};
      active_s = (h11 < H_A) && (v11 < V_A);
      border_s = (h11 == 11'd0) || (h11 == H_A - 11'd1) ||
                 (v11 == 11'd0) || (v11 == V_A - 11'd1);
      sprite_s = (h11 >= x11) && (h11 < x11 + SIZE11) &&
                 (v11 >= y11) && (v11 < y11 + SIZE11);
      // First blanking pixel after the last active line: once per frame.
      tick_s   = (h11 == H_A) && (v11 == V_A);
      if (!active_s) begin
         rgb_d = 3'b000;
      end else if (border_s) begin
         rgb_d = 3'b111;
      end else if (sprite_s) begin
         rgb_d = FG;
      end else begin
         rgb_d = BG;
      end
   end

   // Horizontal motion; the 11-bit sum keeps x+SIZE+STEP from wrapping.
   always_comb begin
      x_d      = x_q;
      dir_x_d  = dir_x_q;
      refl_x_s = 1'b0;
      if (tick_s && bus.en) begin
         if (!dir_x_q) begin
            if (x11 + SIZE11 + STEP11 > H_A) begin
               x_d      = X_MAX;
               dir_x_d  = 1'b1;
               refl_x_s = 1'b1;
            end else begin
               x_d = x_q + STEP10;
            end
         end else begin
            if (x11 < STEP11) begin
               x_d      = 10'd0;
               dir_x_d  = 1'b0;
               refl_x_s = 1'b1;
            end else begin
               x_d = x_q - STEP10;
            end
         end
      end else begin
         x_d = x_q;
      end
   end

   // Vertical motion, mirror of the horizontal axis.
   always_comb begin
      y_d      = y_q;
      dir_y_d  = dir_y_q;
      refl_y_s = 1'b0;
      if (tick_s && bus.en) begin
         if (!dir_y_q) begin
            if (y11 + SIZE11 + STEP11 > V_A) begin
               y_d      = Y_MAX;
               dir_y_d  = 1'b1;
               refl_y_s = 1'b1;
            end else begin
               y_d = y_q + STEP10;
            end
         end else begin
            if (y11 < STEP11) begin
               y_d      = 10'd0;
               dir_y_d  = 1'b0;
               refl_y_s = 1'b1;
            end else begin
               y_d = y_q - STEP10;
            end
         end
      end else begin
         y_d = y_q;
      end
   end

   // A corner hit reflects both axes but counts as one bounce.
   always_comb begin
      if (refl_x_s || refl_y_s) begin
         bounces_d = bounces_q + 8'd1;
      end else begin
         bounces_d = bounces_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rgb_q     <= 3'b000;
         hsync_q   <= 1'b1;
         vsync_q   <= 1'b1;
         x_q       <= 10'd0;
         y_q       <= 10'd0;
         dir_x_q   <= 1'b0;
         dir_y_q   <= 1'b0;
         bounces_q <= 8'd0;
      end else begin
         rgb_q     <= rgb_d;
         hsync_q   <= bus.hsync_in;
         vsync_q   <= bus.vsync_in;
         x_q       <= x_d;
         y_q       <= y_d;
         dir_x_q   <= dir_x_d;
         dir_y_q   <= dir_y_d;
         bounces_q <= bounces_d;
      end
   end

   assign bus.r       = rgb_q[2];
   assign bus.g       = rgb_q[1];
   assign bus.b       = rgb_q[0];
   assign bus.hsync   = hsync_q;
   assign bus.vsync   = vsync_q;
   assign bus.x       = x_q;
   assign bus.y       = y_q;
   assign bus.bounces = bounces_q;
endmodule

// File: tb/tb_vga_sprite.sv
// tb_vga_sprite: directed checks of vga_sprite (640x480 instance) and a small
// 64x64 instance for the simultaneous-corner reflection.
`timescale 1ns/1ps
module tb_vga_sprite;
   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   vga_sprite_if bus ();
   vga_sprite_if cbus ();

   vga_sprite dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   vga_sprite #(
      .H_ACTIVE (64),
      .V_ACTIVE (64),
      .SIZE     (32),
      .STEP     (2)
   ) dut_c (
      .clk (clk),
      .rst (rst),
      .bus (cbus.slave)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one pixel coordinate for one clock, then sample just after the edge.
   task automatic apply(input int h, input int v);
      @(negedge clk);
      bus.hcnt = 10'(h);
      bus.vcnt = 10'(v);
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         apply(640, 480);
         apply(641, 480);
      end
   endtask

   task automatic cticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cbus.hcnt = 10'd64;
         cbus.vcnt = 10'd64;
         @(negedge clk);
         cbus.hcnt = 10'd65;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_pos(input string tag, input int ex, input int ey, input int eb);
      check({tag, ".x"}, 32'(bus.x), 32'(ex));
      check({tag, ".y"}, 32'(bus.y), 32'(ey));
      check({tag, ".bounces"}, 32'(bus.bounces), 32'(eb));
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b0;
      bus.hcnt = 10'd5;
      bus.vcnt = 10'd5;
      bus.hsync_in = 1'b1;
      bus.vsync_in = 1'b1;
      bus.en = 1'b1;
      cbus.hcnt = 10'd0;
      cbus.vcnt = 10'd0;
      cbus.hsync_in = 1'b1;
      cbus.vsync_in = 1'b1;
      cbus.en = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst.rgb", 32'({bus.r, bus.g, bus.b}), 32'd0);
      check("rst.hsync", 32'(bus.hsync), 32'd1);
      check("rst.vsync", 32'(bus.vsync), 32'd1);
      check_pos("rst", 0, 0, 0);
      @(negedge clk);
      rst = 1'b1;

      // Colour and latency
      apply(5, 5);
      check("sprite_in", 32'({bus.r, bus.g, bus.b}), 32'h6);
      apply(0, 10);
      check("border_left", 32'({bus.r, bus.g, bus.b}), 32'h7);
      apply(639, 300);
      check("border_right", 32'({bus.r, bus.g, bus.b}), 32'h7);
      apply(31, 31);
      check("sprite_corner", 32'({bus.r, bus.g, bus.b}), 32'h6);
      apply(32, 5);
      check("sprite_edge_out", 32'({bus.r, bus.g, bus.b}), 32'h1);
      apply(100, 100);
      check("bg", 32'({bus.r, bus.g, bus.b}), 32'h1);
      apply(700, 100);
      check("blank_h", 32'({bus.r, bus.g, bus.b}), 32'h0);
      apply(100, 500);
      check("blank_v", 32'({bus.r, bus.g, bus.b}), 32'h0);

      // Sync delay: hsync follows hsync_in one clock later with that pixel's colour
      @(negedge clk);
      bus.hsync_in = 1'b0;
      bus.hcnt = 10'd0;
      bus.vcnt = 10'd100;
      #1;
      check("hsync_pre", 32'(bus.hsync), 32'd1);
      @(posedge clk);
      #1;
      check("hsync_fall", 32'(bus.hsync), 32'd0);
      check("hsync_rgb", 32'({bus.r, bus.g, bus.b}), 32'h7);
      @(negedge clk);
      bus.hsync_in = 1'b1;
      bus.vsync_in = 1'b0;
      @(posedge clk);
      #1;
      check("hsync_rise", 32'(bus.hsync), 32'd1);
      check("vsync_fall", 32'(bus.vsync), 32'd0);
      @(negedge clk);
      bus.vsync_in = 1'b1;

      // Motion
      ticks(10);
      check_pos("t10", 20, 20, 0);
      apply(20, 20);
      check("moved_sprite", 32'({bus.r, bus.g, bus.b}), 32'h6);
      apply(19, 20);
      check("moved_bg", 32'({bus.r, bus.g, bus.b}), 32'h1);

      // Motion frozen
      @(negedge clk);
      bus.en = 1'b0;
      ticks(5);
      check_pos("en0", 20, 20, 0);
      @(negedge clk);
      bus.en = 1'b1;

      // y reaches its limit, then reflects one tick later
      ticks(214);
      check_pos("t224", 448, 448, 0);
      ticks(1);
      check_pos("t225", 450, 448, 1);
      ticks(79);
      check_pos("t304", 608, 290, 1);
      ticks(1);
      check_pos("t305", 608, 288, 2);
      ticks(1);
      check_pos("t306", 606, 286, 2);

      // Mid-frame asynchronous reset
      apply(300, 200);
      check("pre_rst_rgb", 32'({bus.r, bus.g, bus.b}), 32'h1);
      @(negedge clk);
      bus.hsync_in = 1'b0;
      @(posedge clk);
      #1;
      check("pre_rst_hsync", 32'(bus.hsync), 32'd0);
      #5;
      rst = 1'b0;
      #1;
      check("async_rgb", 32'({bus.r, bus.g, bus.b}), 32'd0);
      check("async_hsync", 32'(bus.hsync), 32'd1);
      check_pos("async", 0, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      bus.hsync_in = 1'b1;
      ticks(1);
      check_pos("restart", 2, 2, 0);

      // Corner reflection on the 64x64 instance
      cticks(16);
      check("c16.x", 32'(cbus.x), 32'd32);
      check("c16.y", 32'(cbus.y), 32'd32);
      check("c16.b", 32'(cbus.bounces), 32'd0);
      cticks(1);
      check("c17.x", 32'(cbus.x), 32'd32);
      check("c17.y", 32'(cbus.y), 32'd32);
      check("c17.b", 32'(cbus.bounces), 32'd1);
      cticks(1);
      check("c18.x", 32'(cbus.x), 32'd30);
      check("c18.y", 32'(cbus.y), 32'd30);
      check("c18.b", 32'(cbus.bounces), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
